// File: rtl/mrd_pkg.sv
// Shared constants and types for the Mixed Radix DFT source stage.
// Bank geometry, word widths and frame limits live here.
package mrd_pkg;

  localparam int NUM_BANKS   = 7;
  localparam int W_BANK_DATA = 30;
  localparam int W_OUT       = 18;
  localparam int W_BANK_ADDR = 8;
  localparam int W_BANK_IDX  = 3;
  localparam int W_DFTPTS    = 12;
  localparam int MAX_DFTPTS  = 1200;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } src_state_t;

endpackage

// File: rtl/mrd_out_sat.sv
// Arithmetic right shift of a bank word followed by
// saturation to the streaming output width.
module mrd_out_sat
  import mrd_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [W_BANK_DATA-1:0] i_d,
  output logic [W_OUT-1:0]       o_d
);

  localparam logic signed [W_BANK_DATA-1:0] MAXV =
    W_BANK_DATA'((1 << (W_OUT - 1)) - 1);
  localparam logic signed [W_BANK_DATA-1:0] MINV =
    W_BANK_DATA'(-(1 << (W_OUT - 1)));

  logic signed [W_BANK_DATA-1:0] w_x;

  assign w_x = $signed(i_d) >>> SHIFT;

  always_comb begin
    o_d = w_x[W_OUT-1:0];
    if (w_x > MAXV) begin
      o_d = {1'b0, {(W_OUT-1){1'b1}}};
    end else if (w_x < MINV) begin
      o_d = {1'b1, {(W_OUT-1){1'b0}}};
    end
  end

endmodule

// File: rtl/mrd_source_rd.sv
// Source stage: reads the 7 banks in natural order (k mod 7, k div 7),
// narrows each word and streams it out with valid/sop/eop framing.
module mrd_source_rd
  import mrd_pkg::*;
#(
  parameter int SHIFT  = 0,
  parameter int RD_LAT = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [W_DFTPTS-1:0]                       dftpts,
  output logic [NUM_BANKS-1:0]                      rden,
  output logic [NUM_BANKS-1:0][W_BANK_ADDR-1:0]     rdaddr,
  input  logic [NUM_BANKS-1:0][W_BANK_DATA-1:0]     rd_real,
  input  logic [NUM_BANKS-1:0][W_BANK_DATA-1:0]     rd_imag,
  output logic                                      src_valid,
  output logic                                      src_sop,
  output logic                                      src_eop,
  output logic [W_OUT-1:0]                          src_real,
  output logic [W_OUT-1:0]                          src_imag,
  output logic [W_DFTPTS-1:0]                       src_dftpts,
  output logic                                      busy,
  output logic                                      done
);

  localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT);
  localparam logic [W_BANK_IDX-1:0] LAST_BANK =
    W_BANK_IDX'(NUM_BANKS - 1);

  src_state_t r_state;
  src_state_t w_state_nxt;

  logic [W_DFTPTS-1:0]    r_n;
  logic [W_DFTPTS-1:0]    r_k;
  logic [W_BANK_IDX-1:0]  r_b;
  logic [W_BANK_ADDR-1:0] r_a;
  logic [1:0]             r_dcnt;

  logic                   w_accept;
  logic                   w_issue;
  logic                   w_last;
  logic [W_BANK_IDX-1:0]  w_b;
  logic [W_BANK_ADDR-1:0] w_a;

  // qualifiers of the read visible on rden this cycle
  logic                  r_rd_vld;
  logic                  r_rd_sop;
  logic                  r_rd_eop;
  logic [W_BANK_IDX-1:0] r_rd_b;

  logic [RD_LAT-1:0]                 r_p_vld;
  logic [RD_LAT-1:0]                 r_p_sop;
  logic [RD_LAT-1:0]                 r_p_eop;
  logic [RD_LAT-1:0][W_BANK_IDX-1:0] r_p_b;

  logic [W_BANK_IDX-1:0]  w_sel_b;
  logic [W_OUT-1:0]       w_re_sat;
  logic [W_OUT-1:0]       w_im_sat;

  assign w_accept = (r_state == IDLE) && start &&
                    (dftpts != '0) &&
                    (dftpts <= W_DFTPTS'(MAX_DFTPTS));

  assign w_issue = w_accept ||
                   ((r_state == READ) && (r_k != r_n));

  assign w_last = w_accept ? (dftpts == W_DFTPTS'(1))
                           : (r_k == r_n - 1'b1);

  assign w_b = w_accept ? '0 : r_b;
  assign w_a = w_accept ? '0 : r_a;

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = READ;
      READ:    if (r_k == r_n) w_state_nxt = DRAIN;
      DRAIN:   if (r_dcnt == DRAIN_LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rden       <= '0;
      rdaddr     <= '0;
      src_dftpts <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_b        <= '0;
      r_a        <= '0;
      r_dcnt     <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_sop   <= 1'b0;
      r_rd_eop   <= 1'b0;
      r_rd_b     <= '0;
    end else begin
      rden <= '0;
      if (w_issue) begin
        rden[w_b]   <= 1'b1;
        rdaddr[w_b] <= w_a;
      end
      if (w_accept) begin
        r_n        <= dftpts;
        src_dftpts <= dftpts;
      end
      // bank/address walk k mod 7, k div 7 without a divider
      if (w_issue) begin
        r_k <= (w_accept ? '0 : r_k) + 1'b1;
        if (w_b == LAST_BANK) begin
          r_b <= '0;
          r_a <= w_a + 1'b1;
        end else begin
          r_b <= w_b + 1'b1;
          r_a <= w_a;
        end
      end
      r_dcnt   <= (r_state == DRAIN) ? r_dcnt + 1'b1 : '0;
      r_rd_vld <= w_issue;
      r_rd_sop <= w_accept;
      r_rd_eop <= w_issue && w_last;
      r_rd_b   <= w_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p_vld <= '0;
      r_p_sop <= '0;
      r_p_eop <= '0;
      r_p_b   <= '0;
    end else begin
      r_p_vld[0] <= r_rd_vld;
      r_p_sop[0] <= r_rd_sop;
      r_p_eop[0] <= r_rd_eop;
      r_p_b[0]   <= r_rd_b;
      for (int i = 1; i < RD_LAT; i++) begin
        r_p_vld[i] <= r_p_vld[i-1];
        r_p_sop[i] <= r_p_sop[i-1];
        r_p_eop[i] <= r_p_eop[i-1];
        r_p_b[i]   <= r_p_b[i-1];
      end
    end
  end

  assign w_sel_b = r_p_b[RD_LAT-1];

  mrd_out_sat #(.SHIFT(SHIFT)) u_sat_re (
    .i_d (rd_real[w_sel_b]),
    .o_d (w_re_sat)
  );

  mrd_out_sat #(.SHIFT(SHIFT)) u_sat_im (
    .i_d (rd_imag[w_sel_b]),
    .o_d (w_im_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_valid <= 1'b0;
      src_sop   <= 1'b0;
      src_eop   <= 1'b0;
      src_real  <= '0;
      src_imag  <= '0;
      done      <= 1'b0;
    end else begin
      src_valid <= r_p_vld[RD_LAT-1];
      src_sop   <= r_p_vld[RD_LAT-1] && r_p_sop[RD_LAT-1];
      src_eop   <= r_p_vld[RD_LAT-1] && r_p_eop[RD_LAT-1];
      if (r_p_vld[RD_LAT-1]) begin
        src_real <= w_re_sat;
        src_imag <= w_im_sat;
      end
      done <= src_valid && src_eop;
    end
  end

endmodule

// File: tb/tb_mrd_source_rd.sv
// Bench for mrd_source_rd: bank RAM model plus a timestamped
// reference of reads, samples, busy and done per frame.
module tb_mrd_source_rd;

  localparam int SH  = 4;
  localparam int LAT = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [11:0]      dftpts = '0;
  logic [6:0]       rden;
  logic [6:0][7:0]  rdaddr;
  logic [6:0][29:0] rd_real = '0;
  logic [6:0][29:0] rd_imag = '0;
  logic             src_valid, src_sop, src_eop;
  logic [17:0]      src_real, src_imag;
  logic [11:0]      src_dftpts;
  logic             busy, done;

  mrd_source_rd #(.SHIFT(SH), .RD_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dftpts     (dftpts),
    .rden       (rden),
    .rdaddr     (rdaddr),
    .rd_real    (rd_real),
    .rd_imag    (rd_imag),
    .src_valid  (src_valid),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .src_real   (src_real),
    .src_imag   (src_imag),
    .src_dftpts (src_dftpts),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [29:0] mre [0:6][0:171];
  logic [29:0] mim [0:6][0:171];

  // one-cycle-latency bank RAMs
  always @(posedge clk) begin
    for (int b = 0; b < 7; b++) begin
      if (rden[b]) begin
        rd_real[b] <= mre[b][rdaddr[b]];
        rd_imag[b] <= mim[b][rdaddr[b]];
      end
    end
  end

  typedef struct {int c; int b; int a;} rd_t;
  typedef struct {
    int c; logic [17:0] re; logic [17:0] im; bit sop; bit eop;
  } smp_t;

  rd_t   rq[$];
  smp_t  sq[$];
  bit    bmap [0:65535];
  bit    dmap [0:65535];
  int    m_free = 0;
  int    m_dpts = 0;
  logic [17:0] last_re = '0;
  logic [17:0] last_im = '0;
  bit    mon_en = 1'b0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [17:0] narrow(input logic [29:0] d);
    int v;
    v = $signed(d);
    v = v >>> SH;
    if (v > 131071) v = 131071;
    else if (v < -131072) v = -131072;
    return v[17:0];
  endfunction

  smp_t       s;
  logic [6:0] er;

  always @(negedge clk) begin
    if (mon_en) begin
      er = '0;
      if (rq.size() > 0 && rq[0].c == cyc) begin
        er = 7'(1) << rq[0].b;
        chk("rdaddr", rdaddr[rq[0].b], rq[0].a);
        void'(rq.pop_front());
      end
      chk("rden", rden, er);
      if (sq.size() > 0 && sq[0].c == cyc) begin
        s = sq.pop_front();
        chk("valid", src_valid, 1);
        chk("sop", src_sop, s.sop);
        chk("eop", src_eop, s.eop);
        last_re = s.re;
        last_im = s.im;
      end else begin
        chk("valid", src_valid, 0);
        chk("sop", src_sop, 0);
        chk("eop", src_eop, 0);
      end
      chk("real", src_real, last_re);
      chk("imag", src_imag, last_im);
      chk("busy", busy, bmap[cyc]);
      chk("done", done, dmap[cyc]);
      if (bmap[cyc]) chk("dftpts", src_dftpts, m_dpts);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int n);
    int t0;
    t0 = cyc;
    for (int k = 0; k < n; k++) begin
      rq.push_back('{t0 + 1 + k, k % 7, k / 7});
      sq.push_back('{t0 + 2 + LAT + k,
                     narrow(mre[k % 7][k / 7]),
                     narrow(mim[k % 7][k / 7]),
                     k == 0, k == n - 1});
    end
    for (int c = t0 + 1; c <= t0 + 1 + LAT + n; c++) bmap[c] = 1'b1;
    dmap[t0 + 2 + LAT + n] = 1'b1;
    m_free = t0 + 2 + LAT + n;
    m_dpts = n;
  endtask

  task automatic pulse(input int n);
    start  = 1'b1;
    dftpts = 12'(n);
    if (cyc >= m_free && n >= 1 && n <= 1200) accept(n);
    tick();
    start  = 1'b0;
    dftpts = 12'($urandom_range(0, 4095));
  endtask

  task automatic wait_idle();
    while (cyc < m_free) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rq.delete();
    sq.delete();
    for (int i = cyc; i < cyc + 1400; i++) begin
      bmap[i] = 1'b0;
      dmap[i] = 1'b0;
    end
    m_dpts  = 0;
    last_re = '0;
    last_im = '0;
    m_free  = cyc;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("rst_rden", rden, 0);
    for (int b = 0; b < 7; b++) chk("rst_rdaddr", rdaddr[b], 0);
    chk("rst_valid", src_valid, 0);
    chk("rst_sop", src_sop, 0);
    chk("rst_eop", src_eop, 0);
    chk("rst_real", src_real, 0);
    chk("rst_imag", src_imag, 0);
    chk("rst_dftpts", src_dftpts, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
  endtask

  task automatic fill_ramp();
    for (int b = 0; b < 7; b++)
      for (int a = 0; a < 172; a++) begin
        mre[b][a] = 30'((7 * a + b) * 16);
        mim[b][a] = 30'(-(7 * a + b) * 16);
      end
  endtask

  task automatic fill_rand();
    int v;
    for (int b = 0; b < 7; b++)
      for (int a = 0; a < 172; a++)
        for (int p = 0; p < 2; p++) begin
          case ($urandom_range(0, 2))
            0: v = int'($urandom_range(0, 2 ** 23)) - 2 ** 22;
            1: v = int'($urandom);
            default: v = 131071 * 16 + int'($urandom_range(0, 48)) - 24;
          endcase
          if ($urandom_range(0, 1) == 1 && v > 0) v = -v;
          if (p == 0) mre[b][a] = 30'(v);
          else        mim[b][a] = 30'(v);
        end
  endtask

  initial begin
    tick();
    tick();
    do_reset();
    mon_en = 1'b1;

    fill_ramp();
    pulse(12);
    wait_idle();
    tick();

    fill_rand();
    pulse(1200);
    wait_idle();
    tick();

    fill_ramp();
    mre[0][0] = 30'h1FFFFFF0;  mim[0][0] = 30'h20000000;
    mre[1][0] = 30'h20000000;  mim[1][0] = 30'h1FFFFFF0;
    mre[2][0] = 30'h00000230;  mim[2][0] = 30'h3FFFFFF0;
    mre[3][0] = 30'h3FFFFDD0;  mim[3][0] = 30'h00000230;
    pulse(4);
    wait_idle();
    tick();

    pulse(0);
    tick();
    pulse(1201);
    tick();
    pulse(4095);
    tick();

    fill_ramp();
    pulse(12);
    repeat (5) tick();
    pulse(7);
    wait_idle();
    tick();

    pulse(12);
    repeat (6) tick();
    do_reset();
    fill_rand();
    pulse(60);
    wait_idle();
    tick();

    fill_ramp();
    pulse(12);
    wait_idle();
    pulse(1);
    wait_idle();
    pulse(1);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      fill_rand();
      pulse($urandom_range(1, 80));
      repeat ($urandom_range(0, 10)) tick();
      pulse($urandom_range(0, 30));
      wait_idle();
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
